sd_data_tx: RTL and testbench

Write-path data transmitter for the SD DAT[3:0] bus, sitting directly downstream of the XOR of the raw and OTP block RAMs.
- Reads one 512-byte block (1024 nibbles) through the shared RAM read address.
- Frames it per SD 4-bit wide-bus rules (start bit, data, per-line CRC16, end bit) and drives DAT[3:0].
- Then releases the bus, captures the card's CRC status token and waits out card busy.
- Reports completion and status to the SD controller FSM.

---
 rtl/sd_data_tx.sv | 172 +++++++++++++++++
 tb/tb_sd_data_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sd_data_tx.sv
// sd_data_tx: SD 4-bit wide-bus write-data transmitter (start, 1024 nibbles, per-line CRC16, end bit), then status token and busy wait.
// Latency: istart -> start bit next cycle, first data nibble 2 cycles after istart, END at +1042, bus released at +1043.
// Backpressure: none on the RAM side (fixed 1-cycle read); waits on DAT0 for token/busy. Optional SD_DATA_TX_TIMEOUT_EN bounds the wait.
module sd_data_tx #(
  parameter int NIBBLES = 1024,
  parameter int ADDR_W  = 10
`ifdef SD_DATA_TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  output logic [ADDR_W-1:0] oaddr,
  input  logic [3:0]        irdata,
  input  logic              idata0_sd,
  output logic [3:0]        odata_sd,
  output logic              odata_sd_en,
  output logic              obusy,
  output logic              odone,
  output logic              ocrc_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DATA, S_CRC, S_END, S_TURN, S_STAT, S_BUSY, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [3:0][15:0]  crc;
  logic [3:0][15:0]  crc_upd;
  logic [3:0][15:0]  crc_shl;
  logic [3:0]        crc_msb;
  logic [2:0]        status;
`ifdef SD_DATA_TX_TIMEOUT_EN
  logic [31:0]       tcnt;
`endif

  // CRC16-CCITT (x^16+x^12+x^5+1), MSB-first, one bit per line per cycle
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0} ^ ({16{c[15] ^ b}} & 16'h1021);
  endfunction

  // Next CRC per line for the nibble being captured, plus the serialising shift
  always_comb begin
    crc_upd = '0;
    crc_shl = '0;
    crc_msb = '0;
    for (int i = 0; i < 4; i++) begin
      crc_upd[i] = crc16_step(crc[i], irdata[i]);
      crc_shl[i] = {crc[i][14:0], 1'b0};
      crc_msb[i] = crc[i][15];
    end
  end

  // Transfer sequencer; state names the phase currently on the bus, outputs are registered
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      crc         <= '0;
      status      <= '0;
      oaddr       <= '0;
      odata_sd    <= 4'hF;
      odata_sd_en <= 1'b0;
      obusy       <= 1'b0;
      odone       <= 1'b0;
      ocrc_err    <= 1'b0;
`ifdef SD_DATA_TX_TIMEOUT_EN
      tcnt        <= '0;
`endif
    end else begin
      odone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (istart) begin
            state       <= S_START;
            odata_sd_en <= 1'b1;
            odata_sd    <= 4'b0000;
            oaddr       <= ADDR_W'(1);
            obusy       <= 1'b1;
            ocrc_err    <= 1'b0;
            crc         <= '0;
          end
        end
        S_START: begin
          // nibble 0 is on irdata now (address 0 was held throughout IDLE)
          odata_sd <= irdata;
          crc      <= crc_upd;
          oaddr    <= oaddr + 1'b1;
          cnt      <= '0;
          state    <= S_DATA;
        end
        S_DATA: begin
          if (cnt == ADDR_W'(NIBBLES - 1)) begin
            odata_sd <= crc_msb;
            crc      <= crc_shl;
            oaddr    <= '0;
            cnt      <= '0;
            state    <= S_CRC;
          end else begin
            odata_sd <= irdata;
            crc      <= crc_upd;
            oaddr    <= oaddr + 1'b1;
            cnt      <= cnt + 1'b1;
          end
        end
        S_CRC: begin
          if (cnt[3:0] == 4'd15) begin
            odata_sd <= 4'hF;
            cnt      <= '0;
            state    <= S_END;
          end else begin
            odata_sd <= crc_msb;
            crc      <= crc_shl;
            cnt      <= cnt + 1'b1;
          end
        end
        S_END: begin
          odata_sd_en <= 1'b0;
          odata_sd    <= 4'hF;
          state       <= S_TURN;
        end
        S_TURN: begin
          cnt   <= '0;
          state <= S_STAT;
`ifdef SD_DATA_TX_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        S_STAT: begin
          // cnt 0: hunt start bit; 1..3: status bits; 4: end bit
          if (cnt[2:0] == 3'd0) begin
            if (!idata0_sd) cnt <= ADDR_W'(1);
          end else if (cnt[2:0] != 3'd4) begin
            status <= {status[1:0], idata0_sd};
            cnt    <= cnt + 1'b1;
          end else begin
            ocrc_err <= (status != 3'b010);
            cnt      <= '0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (idata0_sd) begin
            state <= S_DONE;
            odone <= 1'b1;
          end
        end
        S_DONE: begin
          obusy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef SD_DATA_TX_TIMEOUT_EN
      // Bound the STAT+BUSY wait; a start bit or busy release on the limit cycle wins
      if (state == S_STAT || state == S_BUSY) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == 32'(TIMEOUT_CYCLES - 1) &&
            !(state == S_STAT && cnt[2:0] == 3'd0 && !idata0_sd) &&
            !(state == S_BUSY && idata0_sd)) begin
          state    <= S_DONE;
          ocrc_err <= 1'b1;
          odone    <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_sd_data_tx.sv
// tb_sd_data_tx: randomized block transfers checked against a polynomial-division CRC model and a token/busy timing model.
module tb_sd_data_tx;
  localparam int N = 1024;
`ifdef SD_DATA_TX_TIMEOUT_EN
  localparam int TMO = 64;
`endif

  logic       iclk = 1'b0;
  logic       irst = 1'b0;
  logic       istart = 1'b0;
  logic [9:0] oaddr;
  logic [3:0] irdata = 4'h0;
  logic       idata0_sd = 1'b1;
  logic [3:0] odata_sd;
  logic       odata_sd_en, obusy, odone, ocrc_err;

  logic [3:0]  ram [N];
  logic [15:0] obs_crc [4];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 iclk = ~iclk;

  // RAM model with exactly one cycle of read latency
  always @(posedge iclk) irdata <= ram[oaddr];

  sd_data_tx #(
    .NIBBLES(N), .ADDR_W(10)
`ifdef SD_DATA_TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .oaddr(oaddr), .irdata(irdata),
    .idata0_sd(idata0_sd), .odata_sd(odata_sd), .odata_sd_en(odata_sd_en),
    .obusy(obusy), .odone(odone), .ocrc_err(ocrc_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  // Remainder of M(x)*x^16 divided by G(x), by long division over the line's 1024 bits
  function automatic logic [15:0] crc_ref(input int line);
    bit          msg [N+16];
    logic [16:0] g;
    logic [15:0] r;
    g = 17'h11021;
    for (int k = 0; k < N + 16; k++) msg[k] = (k < N) ? ram[k][line] : 1'b0;
    for (int k = 0; k < N; k++)
      if (msg[k])
        for (int j = 0; j <= 16; j++) msg[k+j] = msg[k+j] ^ g[16-j];
    for (int j = 0; j < 16; j++) r[15-j] = msg[N+j];
    return r;
  endfunction

  // DAT0 as the card drives it, n cycles after entering the status phase
  function automatic logic d0_at(input int n, input bit tmo, input logic [2:0] tok,
                                 input int dly, input int bsy);
    if (tmo) return 1'b1;
    if (n < dly) return 1'b1;
    if (n == dly) return 1'b0;
    if (n <= dly + 3) return tok[2-(n-dly-1)];
    if (n == dly + 4) return 1'b1;
    if (n < dly + 5 + bsy) return 1'b0;
    return 1'b1;
  endfunction

  // mode 0: zeros, 1: counting, 2: random. rst_at >= 0 aborts with irst at that data nibble.
  task automatic run_block(input int mode, input logic [2:0] tok, input int dly, input int bsy,
                           input bit poke, input int rst_at, input bit tmo);
    int   exp_n, done_n, ndone;
    logic err_at_done, busy_after;
    logic exp_err;
    for (int k = 0; k < N; k++)
      ram[k] = (mode == 0) ? 4'h0 : (mode == 1) ? 4'(k) : 4'($urandom_range(0, 15));
    step();
    check("idle_busy", obusy, 1'b0);
    istart = 1'b1;
    step();
    istart = 1'b0;
    check("start_bus", {odata_sd_en, odata_sd}, 5'b1_0000);
    check("start_addr", oaddr, 10'd1);
    check("start_busy", obusy, 1'b1);
    check("start_errclr", ocrc_err, 1'b0);
    for (int k = 0; k < N; k++) begin
      step();
      istart = (poke && k == 300);
      if (k == rst_at) begin
        irst = 1'b1;
        #1;
        check("rst_en", odata_sd_en, 1'b0);
        check("rst_busy", obusy, 1'b0);
        check("rst_dat", odata_sd, 4'hF);
        check("rst_addr", oaddr, 10'd0);
        step();
        irst = 1'b0;
        return;
      end
      check($sformatf("dat%0d", k), {odata_sd_en, odata_sd}, {1'b1, ram[k]});
    end
    istart = 1'b0;
    for (int j = 0; j < 16; j++) begin
      step();
      for (int i = 0; i < 4; i++) obs_crc[i][15-j] = odata_sd[i];
    end
    for (int i = 0; i < 4; i++) check($sformatf("crc_line%0d", i), obs_crc[i], crc_ref(i));
    step();
    check("end_bus", {odata_sd_en, odata_sd}, 5'b1_1111);
    step();
    check("turn_bus", {odata_sd_en, odata_sd}, 5'b0_1111);
    exp_n   = dly + 6 + bsy;
    exp_err = (tok != 3'b010);
`ifdef SD_DATA_TX_TIMEOUT_EN
    if (tmo) begin
      exp_n   = TMO;
      exp_err = 1'b1;
    end
`endif
    ndone = 0; done_n = -1; err_at_done = 1'bx; busy_after = 1'bx;
    for (int n = 0; n <= exp_n + 4; n++) begin
      step();
      idata0_sd = d0_at(n, tmo, tok, dly, bsy);
      istart = poke && (n == dly + 5 || n == exp_n);
      if (odone) begin
        ndone++;
        done_n = n;
        err_at_done = ocrc_err;
      end
      if (done_n >= 0 && n == done_n + 1) busy_after = obusy;
    end
    istart = 1'b0;
    idata0_sd = 1'b1;
    check("done_count", ndone, 1);
    check("done_cycle", done_n, exp_n);
    check("done_err", err_at_done, exp_err);
    check("busy_after_done", busy_after, 1'b0);
    step();
    check("err_hold", ocrc_err, exp_err);
    check("idle_bus", {odata_sd_en, odata_sd}, 5'b0_1111);
  endtask

  initial begin
    for (int k = 0; k < N; k++) ram[k] = 4'h0;
    irst = 1'b1;
    #12;
    check("reset_bus", {odata_sd_en, odata_sd}, 5'b0_1111);
    check("reset_addr", oaddr, 10'd0);
    check("reset_flags", {obusy, odone, ocrc_err}, 3'b000);
    irst = 1'b0;

    run_block(0, 3'b010, 2, 5, 1'b0, -1, 1'b0);   // all-zero block, token at T+1046
    run_block(1, 3'b010, 0, 0, 1'b0, -1, 1'b0);   // counting pattern, busy already released
    run_block(2, 3'b101, 3, 2, 1'b0, -1, 1'b0);   // bad token
    run_block(2, 3'b010, 1, 4, 1'b0, -1, 1'b0);   // next istart clears the error
    run_block(2, 3'b010, 0, 0, 1'b0, 500, 1'b0);  // reset mid-DATA
    run_block(1, 3'b010, 2, 3, 1'b0, -1, 1'b0);   // restart from address 0
    run_block(2, 3'b010, 2, 6, 1'b1, -1, 1'b0);   // stray istart in DATA, BUSY, DONE
    for (int r = 0; r < 3; r++)
      run_block(2, 3'($urandom_range(0, 7)), $urandom_range(0, 5), $urandom_range(0, 8),
                1'b0, -1, 1'b0);
`ifdef SD_DATA_TX_TIMEOUT_EN
    run_block(2, 3'b010, 0, 0, 1'b0, -1, 1'b1);   // card never answers
    run_block(2, 3'b010, 1, 1, 1'b0, -1, 1'b0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
